// File: rtl/oam_dma.sv
// Sprite-memory DMA: a CPU write to TRIGGER_ADDR copies page {page,00..FF} to OAM_ADDR.
// Latency: 513 stall cycles when triggered on an even cycle, 514 on an odd cycle.
// Backpressure: cpu_rdy is held low for the whole transfer; CPU bus activity is ignored until IDLE.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR     = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_we,
    input  logic [7:0]  mem_d_in,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [7:0]  latch_q, latch_d;
    logic        parity_q;

    // State and datapath registers; reset wins over any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            cnt_q    <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            latch_q  <= latch_d;
            parity_q <= ~parity_q;
        end
    end

    // Next-state and bus muxing; IDLE (and reset) is a transparent CPU pass-through.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_we    = cpu_we;
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b1;

        case (state_q)
            IDLE: begin
                dma_busy = 1'b0;
                // The trigger write itself still reaches the bus unchanged.
                if (cpu_we && (cpu_addr == TRIGGER_ADDR)) begin
                    page_d  = cpu_d_out;
                    cnt_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                cpu_rdy = 1'b0;
                mem_we  = 1'b0;
                // Reads must land on even cycles; an odd HALT is followed directly by READ.
                state_d = parity_q ? READ : ALIGN;
            end
            ALIGN: begin
                cpu_rdy = 1'b0;
                mem_we  = 1'b0;
                state_d = READ;
            end
            READ: begin
                cpu_rdy  = 1'b0;
                mem_we   = 1'b0;
                mem_addr = {page_q, cnt_q};
                latch_d  = mem_d_in;
                state_d  = WRITE;
            end
            WRITE: begin
                cpu_rdy   = 1'b0;
                mem_we    = 1'b1;
                mem_addr  = OAM_ADDR;
                mem_d_out = latch_q;
                cnt_d     = cnt_q + 8'd1;
                state_d   = (cnt_q == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held the bus looks idle even before the reset edge lands.
        if (rst) begin
            mem_addr  = cpu_addr;
            mem_d_out = cpu_d_out;
            mem_we    = cpu_we;
            cpu_rdy   = 1'b1;
            dma_busy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_we;
    logic [7:0]  mem_d_in;
    logic        dma_busy;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    bit          par;

    oam_dma #(.TRIGGER_ADDR(16'h4014), .OAM_ADDR(16'h2004)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_d_out (mem_d_out),
        .mem_we    (mem_we),
        .mem_d_in  (mem_d_in),
        .dma_busy  (dma_busy)
    );

    assign mem_d_in = mem[mem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; par mirrors the cycle parity (0 on the first cycle after a reset edge).
    task automatic tick;
        @(posedge clk);
        par = rst ? 1'b0 : ~par;
        #1;
    endtask

    task automatic align(input bit p);
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        if (par != p) tick;
    endtask

    // Trigger one transfer of page pg and scoreboard every stalled cycle.
    task automatic run(input logic [7:0] pg, input int exp_stall, input int exp_first,
                       input logic [7:0] exp_w0, input logic [7:0] exp_wl, input string tag);
        int stall = 0;
        int wcnt  = 0;
        int rcnt  = 0;
        int bad   = 0;
        int first = -1;
        logic [7:0] w0 = 8'h00;
        logic [7:0] wl = 8'h00;
        cpu_addr  = 16'h4014;
        cpu_d_out = pg;
        cpu_we    = 1'b1;
        #1;
        chk({tag, "_trig_addr"}, mem_addr, 16'h4014);
        chk({tag, "_trig_we"}, mem_we, 1'b1);
        chk({tag, "_trig_dat"}, mem_d_out, pg);
        chk({tag, "_trig_rdy"}, cpu_rdy, 1'b1);
        tick;
        // Keep hammering the trigger address with another page while busy.
        cpu_d_out = 8'h33;
        #1;
        for (int n = 0; n < 600; n++) begin
            if (cpu_rdy) break;
            stall++;
            if (n == 200) begin
                cpu_addr  = 16'h1234;
                cpu_d_out = 8'h99;
                cpu_we    = 1'b1;
                #1;
            end
            if (mem_we) begin
                if (mem_addr !== 16'h2004) bad++;
                if (mem_d_out !== (wcnt[7:0] ^ pg ^ 8'h58)) bad++;
                if (wcnt == 0) w0 = mem_d_out;
                wl = mem_d_out;
                wcnt++;
            end else if (mem_addr !== cpu_addr) begin
                if (first < 0) first = n;
                if (mem_addr !== {pg, rcnt[7:0]}) bad++;
                rcnt++;
            end
            tick;
        end
        chk({tag, "_stall"}, stall, exp_stall);
        chk({tag, "_writes"}, wcnt, 256);
        chk({tag, "_reads"}, rcnt, 256);
        chk({tag, "_seq_bad"}, bad, 0);
        chk({tag, "_first_read_idx"}, first, exp_first);
        chk({tag, "_first_wdat"}, w0, exp_w0);
        chk({tag, "_last_wdat"}, wl, exp_wl);
        // Return cycle: immediate pass-through of the pending CPU write.
        chk({tag, "_ret_rdy"}, cpu_rdy, 1'b1);
        chk({tag, "_ret_busy"}, dma_busy, 1'b0);
        chk({tag, "_ret_addr"}, mem_addr, 16'h1234);
        chk({tag, "_ret_dat"}, mem_d_out, 8'h99);
        chk({tag, "_ret_we"}, mem_we, 1'b1);
        cpu_we = 1'b0;
        tick;
        chk({tag, "_no_retrig"}, dma_busy, 1'b0);
    endtask

    initial begin
        logic [15:0] va [4];
        logic [7:0]  vd [4];
        logic        vw [4];
        bit          found;
        int          ow;

        for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ a[15:8] ^ 8'h58;

        // Reset held, with a trigger-looking write on the bus.
        rst       = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h07;
        cpu_we    = 1'b1;
        par       = 1'b0;
        tick;
        tick;
        tick;
        chk("rst_rdy", cpu_rdy, 1'b1);
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_addr", mem_addr, 16'h4014);
        chk("rst_we", mem_we, 1'b1);
        chk("rst_dat", mem_d_out, 8'h07);
        rst = 1'b0;

        // Even-cycle trigger, page 02: data 5A..A5.
        run(8'h02, 513, 1, 8'h5A, 8'hA5, "p02_even");

        // Odd-cycle trigger adds one ALIGN cycle.
        align(1'b1);
        run(8'h02, 514, 2, 8'h5A, 8'hA5, "p02_odd");

        // Top page: reads FF00..FFFF, counter wraps, never touches 0000.
        align(1'b0);
        run(8'hFF, 513, 1, 8'hA7, 8'h58, "pFF");

        // Reset in the middle of a transfer (read of byte 100 = 0x1064).
        align(1'b0);
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h10;
        cpu_we    = 1'b1;
        tick;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        found    = 1'b0;
        #1;
        for (int n = 0; n < 600; n++) begin
            if (!mem_we && mem_addr === 16'h1064) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        chk("mid_found_byte100", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", cpu_rdy, 1'b1);
        chk("mid_rst_busy", dma_busy, 1'b0);
        chk("mid_rst_addr", mem_addr, 16'h0000);
        tick;
        rst = 1'b0;
        #1;
        chk("mid_after_rdy", cpu_rdy, 1'b1);
        chk("mid_after_busy", dma_busy, 1'b0);
        ow = 0;
        for (int n = 0; n < 20; n++) begin
            if (mem_we && mem_addr === 16'h2004) ow++;
            tick;
        end
        chk("mid_no_oam_writes", ow, 0);
        run(8'h10, par ? 514 : 513, par ? 2 : 1, 8'h48, 8'hB7, "p10_restart");

        // Non-trigger traffic in IDLE: pure pass-through, never starts a transfer.
        va[0] = 16'h4015; vd[0] = 8'hC3; vw[0] = 1'b1;
        va[1] = 16'h4014; vd[1] = 8'h02; vw[1] = 1'b0;
        va[2] = 16'h2004; vd[2] = 8'h5A; vw[2] = 1'b1;
        va[3] = 16'hFFFF; vd[3] = 8'hFF; vw[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr  = va[i];
            cpu_d_out = vd[i];
            cpu_we    = vw[i];
            #1;
            chk("pt_addr", mem_addr, va[i]);
            chk("pt_dat", mem_d_out, vd[i]);
            chk("pt_we", mem_we, vw[i]);
            chk("pt_rdy", cpu_rdy, 1'b1);
            tick;
            chk("pt_no_start", dma_busy, 1'b0);
        end
        cpu_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
REQ-002 Parameter OAM_ADDR, 16'h2004, destination address of every DMA write.
REQ-003 clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cpu_addr  in  16  CPU bus address.
REQ-006 cpu_d_out  in  8  CPU write data.
REQ-007 cpu_we  in  1  CPU write strobe.
REQ-008 cpu_rdy  out  1  1 = CPU may advance; 0 = CPU stalled.
REQ-009 mem_addr  out  16  shared memory bus address.
REQ-010 mem_d_out  out  8  shared bus write data.
REQ-011 mem_we  out  1  shared bus write strobe.
REQ-012 mem_d_in  in  8  shared bus read data, valid in the same cycle as mem_addr.
REQ-013 dma_busy  out  1  high whenever state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, HALT, ALIGN, READ, WRITE; registers: state, page[7:0], cnt[7:0], latch[7:0], parity.
REQ-015 parity SHALL toggle every cycle; it is 0 in the first cycle after reset.
REQ-016 IDLE: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_we=cpu_we, cpu_rdy=1 (combinational pass-through).
REQ-017 IDLE with cpu_we=1 and cpu_addr==TRIGGER_ADDR: the write SHALL pass to the bus unchanged; page<=cpu_d_out, cnt<=0, next state HALT.
REQ-018 HALT (1 cycle): cpu_rdy=0, mem_we=0, mem_addr=cpu_addr; next READ if parity==1 in HALT, else ALIGN.
REQ-019 ALIGN (1 cycle): outputs as HALT; next READ.
REQ-020 READ: mem_addr={page,cnt}, mem_we=0, cpu_rdy=0; latch<=mem_d_in at the clock edge; next WRITE.
REQ-021 READ SHALL occur only on cycles with parity==0.
REQ-022 WRITE: mem_addr=OAM_ADDR, mem_d_out=latch, mem_we=1, cpu_rdy=0; cnt<=cnt+1 (8-bit wrap).
REQ-023 WRITE with cnt==8'hFF SHALL go to IDLE; otherwise READ.
REQ-024 Total stall: trigger on parity 0 -> 513 cycles of cpu_rdy=0; trigger on parity 1 -> 514 cycles.
REQ-025 Exactly 256 bus writes to OAM_ADDR per transfer, source order {page,00}..{page,FF}; no address outside the page is read.
REQ-026 cpu_we/cpu_addr SHALL be ignored in every non-IDLE state; no retrigger, no pass-through writes.
REQ-027 The cycle returning to IDLE SHALL give pass-through behaviour and cpu_rdy=1 immediately.
REQ-028 Reads of TRIGGER_ADDR (cpu_we=0) SHALL NOT start a transfer.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=IDLE, cnt=0, page=0, latch=0, parity=0, regardless of current state.
REQ-030 While rst=1 and after its edge: cpu_rdy=1, dma_busy=0, bus outputs in IDLE pass-through.
REQ-031 Reset mid-transfer SHALL abandon it with no further OAM_ADDR writes; the next trigger restarts at cnt=0.

Verification
REQ-032 Memory[0x0200+i]=i^8'h5A; write 8'h02 to 4014 on parity 0 -> cpu_rdy low 513 cycles; first read addr 0x0200; OAM writes 5A,5B,...,A5 in order.
REQ-033 Same trigger on parity 1 -> one ALIGN cycle, cpu_rdy low 514 cycles, first READ on parity 0.
REQ-034 Page 8'hFF -> reads 0xFF00..0xFFFF, cnt wraps to 0, return to IDLE; no read of 0x0000.
REQ-035 Assert rst during cycle of byte 100 -> next cycle IDLE, cpu_rdy=1, no further 0x2004 writes; retrigger starts at {page,00}.
REQ-036 Write to 0x4015, read of 0x4014, write to 0x4014 during active DMA -> no new transfer; IDLE pass-through matches CPU bus bit-for-bit.
